// File: rtl/render_sequencer.sv
// render_sequencer: per-frame scheduler that loads the object once, then runs clear/project/draw per vsync
// Optional watchdog: define RENDER_WATCHDOG_EN.
// Ports: Clk, Reset_n (async active-low); frame_clk raw VGA_VS (async);
//   load_done/clear_done/proj_done/draw_done engine completions; fifo_empty triangle FIFO empty;
//   load_obj/clear_start/proj_start/draw_start one-cycle engine starts; frame_clk_rising_edge synced vsync pulse;
//   frame_done buffer swap pulse; busy (not in WAIT_VS); overrun_cnt saturating missed vsyncs; error sticky watchdog.
module render_sequencer #(
   parameter int TIMEOUT_W = 20,
   parameter int OVR_W     = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             frame_clk,
   input  logic             load_done,
   input  logic             clear_done,
   input  logic             proj_done,
   input  logic             draw_done,
   input  logic             fifo_empty,
   output logic             load_obj,
   output logic             clear_start,
   output logic             proj_start,
   output logic             draw_start,
   output logic             frame_clk_rising_edge,
   output logic             frame_done,
   output logic             busy,
   output logic [OVR_W-1:0] overrun_cnt,
   output logic             error
);
   typedef enum logic [2:0] {LOAD, LOAD_WAIT, WAIT_VS, CLEAR, RENDER, DRAIN, SWAP} state_t;
   state_t st, nxt;
   logic vs_s1, vs_s2, vs_q, dd_seen, drain_exit, timeout;
   logic load_d, clear_d, render_d, swap_d;
   // draw_done counts for the drain only once project has finished
   assign drain_exit = fifo_empty && (draw_done || dd_seen);
`ifdef RENDER_WATCHDOG_EN
   logic [TIMEOUT_W-1:0] wd;
   logic wd_run;
   assign wd_run  = st inside {LOAD_WAIT, CLEAR, RENDER, DRAIN};
   assign timeout = wd_run && (&wd);
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         wd    <= '0;
         error <= 1'b0;
      end else begin
         wd    <= (nxt != st) ? '0 : (wd_run && !(&wd)) ? wd + 1'b1 : wd;
         error <= error | timeout;
      end
`else
   assign timeout = 1'b0;
   // TIMEOUT_W only sizes the watchdog; this is 0 for any legal width
   assign error   = TIMEOUT_W < 1;
`endif
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         st                    <= LOAD;
         load_obj              <= 1'b0;
         clear_start           <= 1'b0;
         proj_start            <= 1'b0;
         draw_start            <= 1'b0;
         frame_done            <= 1'b0;
         vs_s1                 <= 1'b0;
         vs_s2                 <= 1'b0;
         vs_q                  <= 1'b0;
         frame_clk_rising_edge <= 1'b0;
         dd_seen               <= 1'b0;
         overrun_cnt           <= '0;
      end else begin
         st                    <= nxt;
         load_obj              <= load_d;
         clear_start           <= clear_d;
         proj_start            <= render_d;
         draw_start            <= render_d;
         frame_done            <= swap_d;
         vs_s1                 <= frame_clk;
         vs_s2                 <= vs_s1;
         vs_q                  <= vs_s2;
         frame_clk_rising_edge <= vs_s2 && !vs_q;
         dd_seen               <= (st == RENDER) ? proj_done && draw_done : (st == DRAIN) && (dd_seen || draw_done);
         if (frame_clk_rising_edge && st != WAIT_VS && !(&overrun_cnt))
            overrun_cnt <= overrun_cnt + 1'b1;
      end
   always_comb begin
      nxt = st;
      case (st)
         LOAD:      nxt = LOAD_WAIT;
         LOAD_WAIT: nxt = load_done ? WAIT_VS : st;
         WAIT_VS:   nxt = frame_clk_rising_edge ? CLEAR : st;
         CLEAR:     nxt = clear_done ? RENDER : st;
         RENDER:    nxt = proj_done ? DRAIN : st;
         DRAIN:     nxt = drain_exit ? SWAP : st;
         SWAP:      nxt = WAIT_VS;
         default:   nxt = LOAD;
      endcase
      if (timeout) nxt = WAIT_VS;
   end
   // start pulses fire on entry, so a watchdog abort never produces frame_done
   always_comb begin
      load_d   = st == LOAD;
      clear_d  = nxt == CLEAR && st != CLEAR;
      render_d = nxt == RENDER && st != RENDER;
      swap_d   = nxt == SWAP && st != SWAP;
      busy     = st != WAIT_VS;
   end
endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: directed and randomized frame sequences against a frame-level expectation model
module tb_render_sequencer;
   localparam int TW = 12;
   logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, load_done = 1'b0, clear_done = 1'b0;
   logic proj_done = 1'b0, draw_done = 1'b0, fifo_empty = 1'b0;
   logic load_obj, clear_start, proj_start, draw_start, frame_clk_rising_edge, frame_done, busy, error;
   logic [7:0] overrun_cnt;
   int checks = 0, errors = 0, cyc = 0, wide = 0;
   int n_load = 0, n_clear = 0, n_proj = 0, n_draw = 0, n_fd = 0, n_frel = 0;
   int t_load = 0, t_clear = 0, t_proj = 0, t_draw = 0, t_fd = 0, t_frel = 0, t_bfall = 0;
   int tdp = 0, tdv = 0, tdr = 0, exp_ovr = 0, exp_t = 0, fd0 = 0, nc = 0, nl = 0;
   logic [6:0] prev = '0;

   render_sequencer #(.TIMEOUT_W(TW), .OVR_W(8)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .load_done(load_done),
      .clear_done(clear_done), .proj_done(proj_done), .draw_done(draw_done), .fifo_empty(fifo_empty),
      .load_obj(load_obj), .clear_start(clear_start), .proj_start(proj_start), .draw_start(draw_start),
      .frame_clk_rising_edge(frame_clk_rising_edge), .frame_done(frame_done), .busy(busy),
      .overrun_cnt(overrun_cnt), .error(error)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      cyc = cyc + 1;
      if (load_obj && !prev[0]) begin n_load++; t_load = cyc; end
      if (clear_start && !prev[1]) begin n_clear++; t_clear = cyc; end
      if (proj_start && !prev[2]) begin n_proj++; t_proj = cyc; end
      if (draw_start && !prev[3]) begin n_draw++; t_draw = cyc; end
      if (frame_done && !prev[4]) begin n_fd++; t_fd = cyc; end
      if (frame_clk_rising_edge && !prev[5]) begin n_frel++; t_frel = cyc; end
      if (!busy && prev[6]) t_bfall = cyc;
      if (|({frame_clk_rising_edge, frame_done, draw_start, proj_start, clear_start, load_obj} & prev[5:0])) wide++;
      prev = {busy, frame_clk_rising_edge, frame_done, draw_start, proj_start, clear_start, load_obj};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   // w: 0 load_done, 1 clear_done, 2 proj_done, 3 draw_done, 4 proj_done+draw_done
   task automatic pulse(input int w);
      load_done  = w == 0;
      clear_done = w == 1;
      proj_done  = w == 2 || w == 4;
      draw_done  = w == 3 || w == 4;
      tdp = cyc;
      tick(1);
      {load_done, clear_done, proj_done, draw_done} = '0;
   endtask

   task automatic vs_edge();
      frame_clk = 1'b1;
      tdv = cyc;
      tick(4);
      frame_clk = 1'b0;
      tick(4);
   endtask

   function automatic int sat(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // a vsync edge the bench issues while the sequencer is busy is an overrun
   task automatic ov_edge();
      vs_edge();
      exp_ovr = sat(exp_ovr);
   endtask

   initial begin
      tick(3);
      chk("reset_outs", {load_obj, clear_start, proj_start, draw_start, frame_clk_rising_edge, frame_done, busy, error}, 8'b0000_0010);
      chk("reset_ovr", overrun_cnt, 0);
      chk("reset_no_load", n_load, 0);
      Reset_n = 1'b1;
      tdr = cyc;
      tick(5);
      chk("load_lat", t_load, tdr + 2);
      tick(2);
      pulse(0);
      tick(3);
      chk("load_once", n_load, 1);
      chk("load_idle", busy, 0);
      pulse(1); pulse(2); pulse(3);
      tick(2);
      chk("idle_ignore", n_clear + n_proj + n_draw + int'(busy), 0);

      vs_edge();
      chk("vs_lat", t_frel, tdv + 4);
      chk("clear_lat", t_clear, t_frel + 1);
      chk("clear_cnt", n_clear, 1);
      tick(92);
      pulse(1);
      tick(2);
      chk("proj_lat", t_proj, tdp + 2);
      chk("draw_lat", t_draw, tdp + 2);
      tick(48);
      pulse(2);
      tick(19);
      fifo_empty = 1'b1;
      pulse(3);
      fifo_empty = 1'b0;
      tick(3);
      chk("fd_lat", t_fd, tdp + 2);
      chk("fd_cnt", n_fd, 1);
      chk("busy_fall", t_bfall, t_fd + 1);
      chk("order", int'(t_clear < t_proj && t_proj < t_fd), 1);

      vs_edge();
      pulse(1);
      repeat (3) ov_edge();
      pulse(2);
      fifo_empty = 1'b1;
      pulse(3);
      fifo_empty = 1'b0;
      tick(3);
      chk("ovr3", overrun_cnt, exp_ovr);
      chk("ovr3_fd", n_fd, 2);
      nc = n_clear;
      vs_edge();
      chk("ovr3_next", n_clear, nc + 1);
      pulse(1);
      pulse(2);
      fifo_empty = 1'b1;
      pulse(3);
      fifo_empty = 1'b0;
      tick(3);

      for (int f = 0; f < 20; f++) begin
         int mode;
         fd0 = n_fd;
         nc = n_clear;
         mode = $urandom_range(0, 2);
         vs_edge();
         chk("r_vs_lat", t_frel, tdv + 4);
         chk("r_clear", n_clear, nc + 1);
         repeat ($urandom_range(0, 2)) pulse($urandom_range(2, 3));
         repeat ($urandom_range(0, 2)) ov_edge();
         tick($urandom_range(0, 10));
         pulse(1);
         tick(2);
         chk("r_render_lat", t_proj, tdp + 2);
         repeat ($urandom_range(0, 2)) begin
            fifo_empty = 1'($urandom_range(0, 1));
            pulse($urandom_range(0, 1) ? 3 : 1);
         end
         fifo_empty = 1'b0;
         repeat ($urandom_range(0, 1)) ov_edge();
         if (mode == 2) begin
            fifo_empty = 1'b1;
            pulse(4);
            exp_t = tdp + 3;
            tick(1);
            fifo_empty = 1'b0;
         end else begin
            pulse(2);
            fifo_empty = 1'b1;
            tick(1);
            fifo_empty = 1'b0;
            pulse(1);
            repeat ($urandom_range(0, 1)) ov_edge();
            if (mode == 0) begin
               fifo_empty = 1'b1;
               pulse(3);
               fifo_empty = 1'b0;
               exp_t = tdp + 2;
            end else begin
               pulse(3);
               tick($urandom_range(1, 4));
               chk("r_wait_empty", n_fd, fd0);
               fifo_empty = 1'b1;
               exp_t = cyc + 2;
               tick(1);
               fifo_empty = 1'b0;
            end
         end
         tick(4);
         chk("r_fd_lat", t_fd, exp_t);
         chk("r_fd_cnt", n_fd, fd0 + 1);
         chk("r_ovr", overrun_cnt, exp_ovr);
         chk("r_idle", busy, 0);
      end

      vs_edge();
      pulse(1);
      pulse(2);
      repeat (300) ov_edge();
      chk("ovr_sat", overrun_cnt, exp_ovr);
      chk("ovr_sat_255", exp_ovr, 255);
      fd0 = n_fd;
      fifo_empty = 1'b1;
      pulse(3);
      fifo_empty = 1'b0;
      tick(3);
      chk("sat_fd", n_fd, fd0 + 1);

      vs_edge();
      pulse(1);
      chk("proj_hi", proj_start, 1);
      #2 Reset_n = 1'b0;
      #1;
      chk("arst_outs", {load_obj, clear_start, proj_start, draw_start, frame_clk_rising_edge, frame_done, busy, error}, 8'b0000_0010);
      chk("arst_ovr", overrun_cnt, 0);
      exp_ovr = 0;
      nl = n_load;
      tick(3);
      chk("rst_quiet", n_load, nl);
      Reset_n = 1'b1;
      tdr = cyc;
      tick(4);
      chk("reload_lat", t_load, tdr + 2);
      chk("reload_cnt", n_load, nl + 1);
      pulse(0);
      tick(2);

      fd0 = n_fd;
      vs_edge();
      tick((1 << TW) + 10);
`ifdef RENDER_WATCHDOG_EN
      chk("wd_error", error, 1);
      chk("wd_idle", busy, 0);
      chk("wd_no_fd", n_fd, fd0);
`else
      chk("nowd_error", error, 0);
      chk("nowd_stuck", busy, 1);
      chk("nowd_no_fd", n_fd, fd0);
`endif
      chk("no_wide", wide, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
